// File: rtl/dct_cepstrum.sv
// DCT-II cepstrum stage: buffers NUM_FILTERS log-mel energies, then runs one MAC per cycle over an elaboration-time cosine ROM.
// Optional macro DCT_LIFTER_EN adds a LIFT state that applies the sinusoidal lifter before saturation.
module dct_cepstrum #(
  parameter int NUM_FILTERS = 40,
  parameter int NUM_CEPS    = 12,
  parameter int IN_WIDTH    = 32,
  parameter int COEF_WIDTH  = 16,
  parameter int OUT_WIDTH   = 32,
  parameter int ACC_WIDTH   = IN_WIDTH + COEF_WIDTH + $clog2(NUM_FILTERS) + 1,
  parameter int SKIP_C0     = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid_i,
  input  logic [$clog2(NUM_FILTERS)-1:0] in_ptr_i,
  input  logic signed [IN_WIDTH-1:0]     in_data_i,
  output logic                           in_ready_o,
  input  logic                           start_i,
  output logic                           busy_o,
  output logic                           ceps_valid_o,
  output logic [$clog2(NUM_CEPS)-1:0]    ceps_ptr_o,
  output logic signed [OUT_WIDTH-1:0]    ceps_o,
  output logic                           done_o
);

  localparam int  PTR_W    = $clog2(NUM_FILTERS);
  localparam int  CPTR_W   = $clog2(NUM_CEPS);
  localparam int  NUM_ROWS = NUM_CEPS + SKIP_C0;
  localparam int  K_W      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int  PROD_W   = IN_WIDTH + COEF_WIDTH;
  localparam int  SH       = COEF_WIDTH - 1;
  localparam real PI       = 3.14159265358979323846;

  // Cosine for x in [0, 2*PI): fold into [0, PI/2] and sum a Taylor series.
  function automatic real cos_q(input real x_in);
    real x, t, s;
    bit  neg;
    x   = x_in;
    neg = 1'b0;
    if (x > PI) x = 2.0 * PI - x;
    if (x > PI / 2.0) begin
      x   = PI - x;
      neg = 1'b1;
    end
    t = 1.0;
    s = 1.0;
    for (int i = 1; i <= 14; i++) begin
      t = -t * x * x / real'((2 * i - 1) * (2 * i));
      s = s + t;
    end
    return neg ? -s : s;
  endfunction

  function automatic int round_r(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  function automatic logic signed [COEF_WIDTH-1:0] coef_val(input int k, input int n);
    int m, q, qmax;
    qmax = (1 << (COEF_WIDTH - 1)) - 1;
    m    = (k * (2 * n + 1)) % (4 * NUM_FILTERS);
    q    = round_r(real'(qmax) * cos_q(PI * real'(m) / real'(2 * NUM_FILTERS)));
    if (q > qmax)      q = qmax;
    if (q < -qmax - 1) q = -qmax - 1;
    return COEF_WIDTH'(q);
  endfunction

`ifdef DCT_LIFTER_EN
  localparam int LIFT_W = 16;
  localparam int SRC_W  = ACC_WIDTH + LIFT_W;

  // L[k] = 1 + 11*sin(pi*k/22) in Q8.8; sin taken as cos of the distance to PI/2.
  function automatic logic [LIFT_W-1:0] lift_val(input int k);
    real d;
    d = PI / 2.0 - PI * real'(k) / 22.0;
    if (d < 0.0) d = -d;
    return LIFT_W'(round_r(256.0 * (1.0 + 11.0 * cos_q(d))));
  endfunction

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_LIFT, S_EMIT, S_DONE} state_t;
`else
  localparam int SRC_W = ACC_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_EMIT, S_DONE} state_t;
`endif

  state_t                      r_state, w_state_nxt;
  logic signed [IN_WIDTH-1:0]  r_buf [NUM_FILTERS];
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [PTR_W-1:0]            r_n;
  logic [K_W-1:0]              r_k;
  logic                        r_busy, r_ceps_vld, r_done;
  logic [CPTR_W-1:0]           r_ceps_ptr;
  logic signed [OUT_WIDTH-1:0] r_ceps;

  logic signed [COEF_WIDTH-1:0] w_rom [NUM_ROWS][NUM_FILTERS];
  logic signed [COEF_WIDTH-1:0] w_coef;
  logic signed [IN_WIDTH-1:0]   w_samp;
  logic signed [PROD_W-1:0]     w_prod;
  logic signed [ACC_WIDTH-1:0]  w_sh;
  logic signed [SRC_W-1:0]      w_src;
  logic [OUT_WIDTH-1:0]         w_sat;
  logic [K_W-1:0]               w_kidx;
  logic                         w_last_n, w_last_k, w_wr_ok;

  for (genvar gk = 0; gk < NUM_ROWS; gk++) begin : g_row
    for (genvar gn = 0; gn < NUM_FILTERS; gn++) begin : g_col
      localparam logic signed [COEF_WIDTH-1:0] C = coef_val(gk, gn);
      assign w_rom[gk][gn] = C;
    end
  end

  assign w_coef   = w_rom[r_k][r_n];
  assign w_samp   = r_buf[r_n];
  assign w_prod   = $signed({{COEF_WIDTH{w_samp[IN_WIDTH-1]}}, w_samp}) *
                    $signed({{IN_WIDTH{w_coef[COEF_WIDTH-1]}}, w_coef});
  assign w_sh     = r_acc >>> SH;
  assign w_last_n = (r_n == PTR_W'(NUM_FILTERS - 1));
  assign w_last_k = (r_k == K_W'(NUM_ROWS - 1));
  assign w_kidx   = r_k - K_W'(SKIP_C0);
  assign w_wr_ok  = in_valid_i && (r_state == S_IDLE) &&
                    ({1'b0, in_ptr_i} < (PTR_W + 1)'(NUM_FILTERS));

`ifdef DCT_LIFTER_EN
  logic [LIFT_W-1:0]       w_lift_rom [NUM_ROWS];
  logic signed [SRC_W-1:0] r_lift;

  for (genvar gk = 0; gk < NUM_ROWS; gk++) begin : g_lift
    localparam logic [LIFT_W-1:0] L = lift_val(gk);
    assign w_lift_rom[gk] = L;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lift <= '0;
    end else if (r_state == S_LIFT) begin
      r_lift <= $signed({{LIFT_W{w_sh[ACC_WIDTH-1]}}, w_sh}) *
                $signed({{ACC_WIDTH{1'b0}}, w_lift_rom[r_k]});
    end
  end

  assign w_src = r_lift >>> 8;
`else
  assign w_src = w_sh;
`endif

  // Clamp when the bits above the output sign are not a pure sign extension.
  always_comb begin
    w_sat = w_src[OUT_WIDTH-1:0];
    if (!(&w_src[SRC_W-1:OUT_WIDTH-1]) && (|w_src[SRC_W-1:OUT_WIDTH-1])) begin
      w_sat = w_src[SRC_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start_i) w_state_nxt = S_MAC;
`ifdef DCT_LIFTER_EN
      S_MAC:  if (w_last_n) w_state_nxt = S_LIFT;
      S_LIFT: w_state_nxt = S_EMIT;
`else
      S_MAC:  if (w_last_n) w_state_nxt = S_EMIT;
`endif
      S_EMIT: w_state_nxt = w_last_k ? S_DONE : S_MAC;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FILTERS; i++) r_buf[i] <= '0;
      r_acc      <= '0;
      r_n        <= '0;
      r_k        <= '0;
      r_busy     <= 1'b0;
      r_ceps_vld <= 1'b0;
      r_done     <= 1'b0;
      r_ceps_ptr <= '0;
      r_ceps     <= '0;
    end else begin
      r_ceps_vld <= 1'b0;
      r_done     <= 1'b0;
      if (w_wr_ok) r_buf[in_ptr_i] <= in_data_i;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_k    <= K_W'(SKIP_C0);
            r_n    <= '0;
            r_acc  <= '0;
            r_busy <= 1'b1;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + {{(ACC_WIDTH-PROD_W){w_prod[PROD_W-1]}}, w_prod};
          r_n   <= r_n + 1'b1;
        end
        S_EMIT: begin
          r_ceps_vld <= 1'b1;
          r_ceps_ptr <= w_kidx[CPTR_W-1:0];
          r_ceps     <= w_sat;
          r_acc      <= '0;
          r_n        <= '0;
          if (!w_last_k) r_k <= r_k + 1'b1;
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o   = (r_state == S_IDLE);
  assign busy_o       = r_busy;
  assign ceps_valid_o = r_ceps_vld;
  assign ceps_ptr_o   = r_ceps_ptr;
  assign ceps_o       = r_ceps;
  assign done_o       = r_done;

endmodule

// File: tb/tb_dct_cepstrum.sv
// Bench for dct_cepstrum: three instances (defaults, SKIP_C0=0, SKIP_C0=0 with 16-bit output) share one stimulus
// stream and are checked cycle by cycle against a real-arithmetic DCT-II model.
module tb_dct_cepstrum;

  localparam int NF = 40;
  localparam int NC = 12;
  localparam int ND = 3;
`ifdef DCT_LIFTER_EN
  localparam int PER = NF + 2;
`else
  localparam int PER = NF + 1;
`endif
  localparam int  T_DONE = NC * PER + 1;
  localparam real PI     = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        start_i = 1'b0;
  logic [5:0]  in_ptr_i = '0;
  logic [31:0] in_data_i = '0;

  logic        a_rdy, a_busy, a_vld, a_done;
  logic [3:0]  a_ptr;
  logic [31:0] a_ceps;
  logic        b_rdy, b_busy, b_vld, b_done;
  logic [3:0]  b_ptr;
  logic [31:0] b_ceps;
  logic        c_rdy, c_busy, c_vld, c_done;
  logic [3:0]  c_ptr;
  logic [15:0] c_ceps;

  logic        rdy[ND], busy[ND], vld[ND], done[ND];
  logic [3:0]  ptr[ND];
  longint      cv[ND];

  int     skipv[ND] = '{1, 0, 0};
  int     owv[ND]   = '{32, 32, 16};
  longint mdl_buf[NF];
  int     n_vec = 0;
  int     n_err = 0;

  always #5 clk = ~clk;

  dct_cepstrum u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ptr_i(in_ptr_i), .in_data_i(in_data_i),
    .in_ready_o(a_rdy), .start_i(start_i), .busy_o(a_busy), .ceps_valid_o(a_vld),
    .ceps_ptr_o(a_ptr), .ceps_o(a_ceps), .done_o(a_done));

  dct_cepstrum #(.SKIP_C0(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ptr_i(in_ptr_i), .in_data_i(in_data_i),
    .in_ready_o(b_rdy), .start_i(start_i), .busy_o(b_busy), .ceps_valid_o(b_vld),
    .ceps_ptr_o(b_ptr), .ceps_o(b_ceps), .done_o(b_done));

  dct_cepstrum #(.SKIP_C0(0), .OUT_WIDTH(16)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ptr_i(in_ptr_i), .in_data_i(in_data_i),
    .in_ready_o(c_rdy), .start_i(start_i), .busy_o(c_busy), .ceps_valid_o(c_vld),
    .ceps_ptr_o(c_ptr), .ceps_o(c_ceps), .done_o(c_done));

  assign rdy[0] = a_rdy;   assign rdy[1] = b_rdy;   assign rdy[2] = c_rdy;
  assign busy[0] = a_busy; assign busy[1] = b_busy; assign busy[2] = c_busy;
  assign vld[0] = a_vld;   assign vld[1] = b_vld;   assign vld[2] = c_vld;
  assign done[0] = a_done; assign done[1] = b_done; assign done[2] = c_done;
  assign ptr[0] = a_ptr;   assign ptr[1] = b_ptr;   assign ptr[2] = c_ptr;
  assign cv[0] = longint'($signed(a_ceps));
  assign cv[1] = longint'($signed(b_ceps));
  assign cv[2] = longint'($signed(c_ceps));

  task automatic check_eq(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint coef_m(input int k, input int n);
    return longint'(32767.0 * $cos(PI * real'(k * (2 * n + 1)) / real'(2 * NF)));
  endfunction

  function automatic longint exp_ceps(input int skip, input int ow, input int j);
    longint acc, v, lim;
    int     k;
    k   = j + skip;
    acc = 0;
    for (int n = 0; n < NF; n++) acc += mdl_buf[n] * coef_m(k, n);
    v = acc >>> 15;
`ifdef DCT_LIFTER_EN
    v = (v * longint'(256.0 * (1.0 + 11.0 * $sin(PI * real'(k) / 22.0)))) >>> 8;
`endif
    lim = longint'(1) <<< (ow - 1);
    if (v > lim - 1) v = lim - 1;
    if (v < -lim)    v = -lim;
    return v;
  endfunction

  function automatic logic [31:0] rand_val();
    logic signed [31:0] v;
    v = $signed($urandom);
    return v >>> $urandom_range(0, 31);
  endfunction

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < ND; d++) begin
      check_eq($sformatf("%s_rdy%0d", tag, d), rdy[d], 1);
      check_eq($sformatf("%s_busy%0d", tag, d), busy[d], 0);
      check_eq($sformatf("%s_vld%0d", tag, d), vld[d], 0);
      check_eq($sformatf("%s_done%0d", tag, d), done[d], 0);
      check_eq($sformatf("%s_ptr%0d", tag, d), ptr[d], 0);
      check_eq($sformatf("%s_ceps%0d", tag, d), cv[d], 0);
    end
  endtask

  task automatic wr(input int p, input logic [31:0] dat);
    @(negedge clk);
    in_valid_i = 1'b1;
    in_ptr_i   = 6'(p);
    in_data_i  = dat;
    if (p < NF) mdl_buf[p] = longint'($signed(dat));
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic load_const(input logic [31:0] dat);
    for (int p = 0; p < NF; p++) wr(p, dat);
  endtask

  // Starts a transform and checks every cycle; dist_cyc injects start/write mid-run, stop_cyc ends early.
  task automatic run_frame(input int dist_cyc, input int stop_cyc, input bit start_wr);
    int  p, j, limit;
    bit  ev;
    limit = (stop_cyc >= 0) ? stop_cyc : T_DONE + 3;
    @(negedge clk);
    for (int d = 0; d < ND; d++) check_eq($sformatf("idle_rdy%0d", d), rdy[d], 1);
    start_i = 1'b1;
    if (start_wr) begin
      p          = $urandom_range(0, NF - 1);
      in_valid_i = 1'b1;
      in_ptr_i   = 6'(p);
      in_data_i  = rand_val();
      mdl_buf[p] = longint'($signed(in_data_i));
    end
    @(posedge clk); #1;
    for (int cyc = 0; cyc <= limit; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
      end
      start_i    = 1'b0;
      in_valid_i = 1'b0;
      ev = (cyc >= PER) && (cyc % PER == 0) && (cyc / PER <= NC);
      for (int d = 0; d < ND; d++) begin
        check_eq($sformatf("vld%0d_c%0d", d, cyc), vld[d], ev);
        check_eq($sformatf("busy%0d_c%0d", d, cyc), busy[d], cyc < T_DONE);
        check_eq($sformatf("done%0d_c%0d", d, cyc), done[d], cyc == T_DONE);
        if (cyc == dist_cyc) check_eq($sformatf("busy_rdy%0d", d), rdy[d], 0);
        if (ev) begin
          j = cyc / PER - 1;
          check_eq($sformatf("ptr%0d_j%0d", d, j), ptr[d], j);
          check_eq($sformatf("ceps%0d_j%0d", d, j), cv[d], exp_ceps(skipv[d], owv[d], j));
        end
      end
      if (cyc + 1 == dist_cyc) begin
        p          = $urandom_range(0, NF - 1);
        start_i    = 1'b1;
        in_valid_i = 1'b1;
        in_ptr_i   = 6'(p);
        in_data_i  = 32'(mdl_buf[p] + 12345);
      end
    end
    if (stop_cyc < 0) begin
      for (int d = 0; d < ND; d++) begin
        check_eq($sformatf("hold_ptr%0d", d), ptr[d], NC - 1);
        check_eq($sformatf("hold_ceps%0d", d), cv[d], exp_ceps(skipv[d], owv[d], NC - 1));
      end
    end
  endtask

  initial begin
    for (int n = 0; n < NF; n++) mdl_buf[n] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_state("post_rst");

    run_frame(-1, -1, 1'b0);
    load_const(32'd1000);
    run_frame(-1, -1, 1'b0);
    load_const(32'd0);
    wr(0, 32'd32768);
    run_frame(-1, -1, 1'b0);
    load_const(32'h7fff_ffff);
    run_frame(-1, -1, 1'b0);
    load_const(32'h8000_0000);
    run_frame(-1, -1, 1'b0);

    for (int f = 0; f < 4; f++) begin
      int nw;
      nw = $urandom_range(5, 60);
      for (int w = 0; w < nw; w++) wr($urandom_range(0, 63), rand_val());
      run_frame(-1, -1, f[0]);
    end

    run_frame(100, -1, 1'b0);
    run_frame(-1, -1, 1'b0);

    run_frame(-1, 150, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    for (int n = 0; n < NF; n++) mdl_buf[n] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < ND; d++) check_eq($sformatf("no_done%0d_c%0d", d, c), done[d], 0);
    end
    run_frame(-1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
